// File: rtl/maxnet_controller_if.sv
// Handshake/control bundle between the MAXNET datapath/host (master) and its controller (slave).
interface maxnet_controller_if;
   logic start;
   logic found;
   logic main_write;
   logic actWrite;
   logic multWrite;
   logic addWrite;
   logic mainRegWrite;
   logic s1;
   logic s2;
   logic s3;
   logic s4;
   logic busy;
   logic done;
   logic timeout;

   modport master (
      output start, found,
      input  main_write, actWrite, multWrite, addWrite, mainRegWrite,
      input  s1, s2, s3, s4, busy, done, timeout
   );

   modport slave (
      input  start, found,
      output main_write, actWrite, multWrite, addWrite, mainRegWrite,
      output s1, s2, s3, s4, busy, done, timeout
   );
endinterface

// File: rtl/maxnet_controller.sv
// MAXNET winner-search sequencer: LOAD/INIT then MULT-ADD-CHECK-FEED until one activation survives.
// Optional iteration limit compiled in with `define MAXNET_TIMEOUT_EN (limit = MAX_ITER).
module maxnet_controller #(
   parameter int unsigned MAX_ITER = 64
) (
   input logic           clk,
   input logic           rst,
   maxnet_controller_if.slave bus
);

   typedef enum logic [2:0] {IDLE, LOAD, INIT, MULT, ADD, CHECK, FEED, DONE} state_t;

   if (MAX_ITER < 1 || MAX_ITER > 255) begin : g_bad_max_iter
      $error("MAX_ITER must be within 1..255");
   end

   state_t state;
   state_t state_d;

   logic main_write_q;
   logic act_write_q;
   logic mult_write_q;
   logic add_write_q;
   logic done_q;
   logic sel_q;
   logic busy_q;

`ifdef MAXNET_TIMEOUT_EN
   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W:0] ITER_LIMIT = (CNT_W+1)'(MAX_ITER);

   logic [CNT_W-1:0] iter_cnt;
   logic [CNT_W-1:0] iter_cnt_d;
   logic             limit_hit;
   logic             timeout_d;
   logic             timeout_q;

   // Limit reached when the CHECK being left completes iteration MAX_ITER
   assign limit_hit = ({1'b0, iter_cnt} + (CNT_W+1)'(1)) == ITER_LIMIT;
`endif

   // Next state (and iteration count when the limit is compiled in)
   always_comb begin
      state_d = state;
`ifdef MAXNET_TIMEOUT_EN
      iter_cnt_d = iter_cnt;
      timeout_d  = 1'b0;
`endif
      unique case (state)
         IDLE: if (bus.start) state_d = LOAD;
         LOAD: begin
            state_d = INIT;
`ifdef MAXNET_TIMEOUT_EN
            iter_cnt_d = '0;
`endif
         end
         INIT:  state_d = MULT;
         MULT:  state_d = ADD;
         ADD:   state_d = CHECK;
         CHECK: begin
`ifdef MAXNET_TIMEOUT_EN
            iter_cnt_d = (iter_cnt == '1) ? iter_cnt : iter_cnt + CNT_W'(1);
`endif
            if (bus.found) state_d = DONE;
`ifdef MAXNET_TIMEOUT_EN
            else if (limit_hit) begin
               state_d   = DONE;
               timeout_d = 1'b1;
            end
`endif
            else state_d = FEED;
         end
         FEED:    state_d = MULT;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register with Moore outputs registered alongside it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         main_write_q <= 1'b0;
         act_write_q  <= 1'b0;
         mult_write_q <= 1'b0;
         add_write_q  <= 1'b0;
         done_q       <= 1'b0;
         sel_q        <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state        <= state_d;
         main_write_q <= (state_d == LOAD);
         act_write_q  <= (state_d == INIT) || (state_d == FEED);
         mult_write_q <= (state_d == MULT);
         add_write_q  <= (state_d == ADD);
         done_q       <= (state_d == DONE);
         sel_q        <= (state_d == FEED);
         busy_q       <= (state_d != IDLE);
      end
   end

`ifdef MAXNET_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iter_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         iter_cnt  <= iter_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.timeout = timeout_q;
`else
   assign bus.timeout = 1'b0;
`endif

   assign bus.main_write   = main_write_q;
   assign bus.actWrite     = act_write_q;
   assign bus.multWrite    = mult_write_q;
   assign bus.addWrite     = add_write_q;
   assign bus.mainRegWrite = done_q;
   assign bus.done         = done_q;
   assign bus.s1           = sel_q;
   assign bus.s2           = sel_q;
   assign bus.s3           = sel_q;
   assign bus.s4           = sel_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_maxnet_controller.sv
// Self-checking bench for maxnet_controller: vector table, corner sequences and a randomized run
// against a schedule-queue reference model.
module tb_maxnet_controller;

`ifdef MAXNET_TIMEOUT_EN
   localparam int unsigned TB_MAX_ITER = 3;
   localparam bit          TB_TO_EN    = 1'b1;
`else
   localparam int unsigned TB_MAX_ITER = 64;
   localparam bit          TB_TO_EN    = 1'b0;
`endif

   // Output vector: {main_write, actWrite, multWrite, addWrite, mainRegWrite, s1..s4, busy, done, timeout}
   localparam logic [11:0] O_IDLE  = 12'h000;
   localparam logic [11:0] O_LOAD  = 12'h804;
   localparam logic [11:0] O_INIT  = 12'h404;
   localparam logic [11:0] O_MULT  = 12'h204;
   localparam logic [11:0] O_ADD   = 12'h104;
   localparam logic [11:0] O_CHECK = 12'h004;
   localparam logic [11:0] O_FEED  = 12'h47C;
   localparam logic [11:0] O_DONE  = 12'h086;
   localparam logic [11:0] O_DONET = 12'h087;

   localparam int P_IDLE = 0, P_LOAD = 1, P_INIT = 2, P_MULT = 3, P_ADD = 4,
                  P_CHECK = 5, P_FEED = 6, P_DONE = 7;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   maxnet_controller_if bus();

   maxnet_controller #(.MAX_ITER(TB_MAX_ITER)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [11:0] dut_o;
   assign dut_o = {bus.main_write, bus.actWrite, bus.multWrite, bus.addWrite, bus.mainRegWrite,
                   bus.s1, bus.s2, bus.s3, bus.s4, bus.busy, bus.done, bus.timeout};

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         if (failures <= 20)
            $display("FAIL %s: got 'h%0h required 'h%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Reference model: a run is a schedule of phases; CHECK decides what gets scheduled next.
   int  sched[$];
   int  m_cur = P_IDLE;
   bit  m_to  = 1'b0;
   int  m_iter;
   int  m_nxt;
   bit  m_nto;

   function automatic logic [11:0] exp_of(input int p, input bit t);
      case (p)
         P_LOAD:  return O_LOAD;
         P_INIT:  return O_INIT;
         P_MULT:  return O_MULT;
         P_ADD:   return O_ADD;
         P_CHECK: return O_CHECK;
         P_FEED:  return O_FEED;
         P_DONE:  return t ? O_DONET : O_DONE;
         default: return O_IDLE;
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sched.delete();
         m_iter = 0;
         m_cur <= P_IDLE;
         m_to  <= 1'b0;
      end else begin
         m_nto = 1'b0;
         if (m_cur == P_IDLE) begin
            if (bus.start) begin
               sched.delete();
               sched.push_back(P_INIT);
               sched.push_back(P_MULT);
               sched.push_back(P_ADD);
               sched.push_back(P_CHECK);
               m_iter = 0;
               m_nxt  = P_LOAD;
            end else m_nxt = P_IDLE;
         end else if (m_cur == P_CHECK) begin
            m_iter = m_iter + 1;
            if (bus.found) m_nxt = P_DONE;
            else if (TB_TO_EN && m_iter == int'(TB_MAX_ITER)) begin
               m_nxt = P_DONE;
               m_nto = 1'b1;
            end else begin
               sched.push_back(P_FEED);
               sched.push_back(P_MULT);
               sched.push_back(P_ADD);
               sched.push_back(P_CHECK);
               m_nxt = sched.pop_front();
            end
         end else if (m_cur == P_DONE) m_nxt = P_IDLE;
         else m_nxt = (sched.size() > 0) ? sched.pop_front() : P_IDLE;
         m_cur <= m_nxt;
         m_to  <= m_nto;
      end
   end

   typedef struct {
      logic        start;
      logic        found;
      logic [11:0] exp;
   } vec_t;

   vec_t tbl[$];

   task automatic add_vec(input logic s, input logic f, input logic [11:0] e);
      vec_t v;
      v.start = s;
      v.found = f;
      v.exp   = e;
      tbl.push_back(v);
   endtask

   initial begin
      int n;
      int dn;
      int to_cnt;
      int last;
      int gaps[$];

      rst = 1'b1;
      bus.start = 1'b0;
      bus.found = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("reset_outputs", dut_o, O_IDLE);
      rst = 1'b0;
      step();
      check("idle_after_reset", dut_o, O_IDLE);

      // Row k: inputs before edge k+1, outputs after it. First a one-iteration run, then three.
      add_vec(1, 0, O_LOAD);  add_vec(0, 0, O_INIT);  add_vec(0, 0, O_MULT);
      add_vec(0, 0, O_ADD);   add_vec(0, 1, O_CHECK); add_vec(0, 1, O_DONE);
      add_vec(0, 0, O_IDLE);
      add_vec(1, 0, O_LOAD);  add_vec(0, 0, O_INIT);  add_vec(0, 0, O_MULT);
      add_vec(0, 0, O_ADD);   add_vec(0, 0, O_CHECK); add_vec(0, 0, O_FEED);
      add_vec(0, 0, O_MULT);  add_vec(0, 0, O_ADD);   add_vec(0, 0, O_CHECK);
      add_vec(0, 0, O_FEED);  add_vec(0, 0, O_MULT);  add_vec(0, 0, O_ADD);
      add_vec(0, 0, O_CHECK); add_vec(0, 1, O_DONE);  add_vec(0, 0, O_IDLE);
      foreach (tbl[i]) begin
         bus.start = tbl[i].start;
         bus.found = tbl[i].found;
         step();
         check($sformatf("vec_%0d", i), dut_o, tbl[i].exp);
      end
      bus.found = 1'b0;

      // start pulsed during MULT is ignored: exactly one done
      bus.start = 1'b1;
      bus.found = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      step();
      check("in_mult", dut_o, O_MULT);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      dn = 0;
      repeat (20) begin
         step();
         if (bus.done) dn++;
      end
      check("start_in_mult_one_done", dn, 1);

      // start held high: back-to-back runs every 7 cycles
      bus.start = 1'b1;
      n = 0;
      last = -1;
      while (gaps.size() < 3 && n < 60) begin
         step();
         n++;
         if (bus.done) begin
            if (last >= 0) gaps.push_back(n - last);
            last = n;
         end
      end
      check("b2b_done_count", gaps.size(), 3);
      foreach (gaps[i]) check($sformatf("b2b_gap_%0d", i), gaps[i], 7);
      bus.start = 1'b0;
      repeat (10) step();
      check("b2b_idle", dut_o, O_IDLE);

      // asynchronous reset during ADD abandons the run
      bus.found = 1'b0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      n = 0;
      while (dut_o != O_ADD && n < 10) begin
         step();
         n++;
      end
      check("reached_add", dut_o, O_ADD);
      #2 rst = 1'b1;
      #1 check("async_reset_outputs", dut_o, O_IDLE);
      step();
      rst = 1'b0;
      bus.found = 1'b1;
      dn = 0;
      repeat (8) begin
         step();
         if (bus.done) dn++;
      end
      check("no_done_after_abort", dn, 0);
      check("idle_after_abort", dut_o, O_IDLE);

      // first run after reset: done after edge 6
      bus.start = 1'b1;
      n = 0;
      do begin
         step();
         bus.start = 1'b0;
         n++;
      end while (!bus.done && n < 30);
      check("post_reset_done_edge", n, 6);
      step();

`ifdef MAXNET_TIMEOUT_EN
      // limit MAX_ITER=3 with found stuck low: timeout with done after edge 14
      bus.found = 1'b0;
      bus.start = 1'b1;
      n = 0;
      do begin
         step();
         bus.start = 1'b0;
         n++;
      end while (!bus.done && n < 40);
      check("timeout_done_edge", n, 14);
      check("timeout_outputs", dut_o, O_DONET);
      step();
      check("timeout_then_idle", dut_o, O_IDLE);
`else
      // no limit: found stuck low never finishes
      bus.found = 1'b0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      dn = 0;
      to_cnt = 0;
      repeat (1000) begin
         step();
         if (bus.done) dn++;
         if (bus.timeout) to_cnt++;
      end
      check("no_limit_no_done", dn, 0);
      check("no_limit_no_timeout", to_cnt, 0);
      check("no_limit_still_busy", bus.busy, 1);
`endif

      // randomized run against the reference model
      rst = 1'b1;
      bus.start = 1'b0;
      step();
      rst = 1'b0;
      repeat (2000) begin
         if (rst) rst = 1'b0;
         else if ($urandom_range(0, 199) == 0) rst = 1'b1;
         bus.start = ($urandom_range(0, 3) == 0);
         bus.found = ($urandom_range(0, 2) == 0);
         step();
         check("random_vs_model", dut_o, exp_of(m_cur, m_to));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
